// File: rtl/mem_initiator.sv
// Burst read/write command master for a single-port memory with 1-cycle read latency.
// Optional: define MEM_INITIATOR_BOUND_CHECK_EN to discard out-of-range bursts and pulse cmd_err.
module mem_initiator #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 3,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_incr,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  cmd_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int PW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW  = $clog2(RSP_DEPTH + 1);
  localparam int CW1 = CW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  incr_q, incr_d;
  logic                  inflight_q, inflight_d;
  logic                  infl_last_q, infl_last_d;
  logic                  ready_q;

  logic [DATA_WIDTH:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0]         wptr_q, rptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH:0]   head;

  logic hs, last_beat, push, pop, issue, oob;

  assign cmd_ready = ready_q && (state_q == S_IDLE);
  assign hs        = cmd_valid && cmd_ready;
  assign last_beat = (cnt_q == '0);
  assign push      = inflight_q;
  assign pop       = rsp_valid && rsp_ready;

  // A pop in the same cycle frees a slot, so counting it keeps 1 beat/cycle at depth 2
  // while still guaranteeing the pending read never lands in a full FIFO.
  assign issue = (state_q == S_RD) &&
                 (({1'b0, count_q} + CW1'(inflight_q)) < (CW1'(RSP_DEPTH) + CW1'(pop)));

`ifdef MEM_INITIATOR_BOUND_CHECK_EN
  logic [ADDR_WIDTH+LEN_WIDTH:0] span;
  logic                          err_q;
  assign span    = (ADDR_WIDTH+LEN_WIDTH+1)'(cmd_addr) + (ADDR_WIDTH+LEN_WIDTH+1)'(cmd_len);
  assign oob     = |(span >> ADDR_WIDTH);
  assign cmd_err = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= hs && oob;
  end
`else
  assign oob     = 1'b0;
  assign cmd_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    incr_d      = incr_q;
    inflight_d  = issue;
    infl_last_d = last_beat;
    case (state_q)
      S_IDLE: begin
        if (hs && !oob) begin
          addr_d  = cmd_addr;
          data_d  = cmd_wdata;
          cnt_d   = cmd_len;
          incr_d  = cmd_incr;
          state_d = cmd_write ? S_WR : S_RD;
        end
      end
      S_WR: begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        if (incr_q) data_d = data_q + DATA_WIDTH'(1);
        cnt_d = cnt_q - LEN_WIDTH'(1);
        if (last_beat) state_d = S_IDLE;
      end
      S_RD: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          cnt_d  = cnt_q - LEN_WIDTH'(1);
          if (last_beat) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      incr_q      <= 1'b0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      incr_q      <= incr_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      ready_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr_q] <= {infl_last_q, mem_rdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= (wptr_q == PW'(RSP_DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      if (pop)  rptr_q <= (rptr_q == PW'(RSP_DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CW'(RSP_DEPTH))));

  assign head      = fifo_mem[rptr_q];
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = rsp_valid ? head[DATA_WIDTH-1:0] : '0;
  assign rsp_last  = rsp_valid && head[DATA_WIDTH];

  assign mem_wr_en = (state_q == S_WR);
  assign mem_rd_en = issue;
  assign mem_addr  = (state_q != S_IDLE) ? addr_q : '0;
  assign mem_wdata = (state_q == S_WR) ? data_q : '0;

endmodule

// File: tb/tb_mem_initiator.sv
// Testbench for mem_initiator: attached 0xFF-initialised memory, reference model of memory
// contents and expected response stream, per-scenario tasks with inline checks.
module tb_mem_initiator;
  localparam int AW = 3, DW = 8, LW = 3, DEPTH = 2, NW = 1 << AW;

  logic          clk, reset;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_incr;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [LW-1:0] cmd_len;
  logic          rsp_valid, rsp_ready, rsp_last, cmd_err;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en, mem_rd_en;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_incr(cmd_incr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .cmd_err(cmd_err),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port memory, 1-cycle read latency; controls sampled mid-cycle, applied at the edge.
  logic [DW-1:0] mem_arr [NW];
  initial begin
    logic          s_wr, s_rd;
    logic [AW-1:0] s_a;
    logic [DW-1:0] s_d;
    for (int i = 0; i < NW; i++) mem_arr[i] = 8'hFF;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      s_wr = mem_wr_en; s_rd = mem_rd_en; s_a = mem_addr; s_d = mem_wdata;
      @(posedge clk);
      if (s_rd) mem_rdata <= mem_arr[s_a];
      if (s_wr) mem_arr[s_a] = s_d;
    end
  end

  // Passive capture of observed traffic.
  logic [DW:0]   got_q[$];
  int            got_cyc[$];
  logic [AW-1:0] rd_addr_q[$];
  int            rd_cyc[$];
  int            wr_cnt = 0, err_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_last, rsp_data});
      got_cyc.push_back(cyc);
    end
    if (mem_rd_en) begin
      rd_addr_q.push_back(mem_addr);
      rd_cyc.push_back(cyc);
    end
    if (mem_wr_en) wr_cnt++;
    if (cmd_err) err_cnt++;
    if (mem_rd_en && mem_wr_en) both_cnt++;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [NW];
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_err;
  int            n_cmp = 0, n_fail = 0;
  bit            rnd_ready = 0;

  task automatic send(input bit w, input bit inc, input int a, input int d, input int len);
    bit ok = 0;
    bit oob;
    cmd_valid = 1; cmd_write = w; cmd_incr = inc;
    cmd_addr = AW'(a); cmd_wdata = DW'(d); cmd_len = LW'(len);
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk); ok = cmd_ready;
      @(posedge clk); #1;
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
    cmd_valid = 0;
    if (!ok) $display("FAIL cmd_accept_timeout addr=%0d len=%0d", a, len);
`ifdef MEM_INITIATOR_BOUND_CHECK_EN
    oob = (a + len > NW - 1);
`else
    oob = 0;
`endif
    if (oob) exp_err++;
    else if (w) begin
      for (int i = 0; i <= len; i++) ref_mem[(a + i) % NW] = inc ? DW'(d + i) : DW'(d);
    end else begin
      for (int i = 0; i <= len; i++) begin
        exp_q.push_back({(i == len), ref_mem[(a + i) % NW]});
        exp_addr.push_back(AW'((a + i) % NW));
      end
    end
  endtask

  task automatic drain(input int g0);
    int k = 0;
    while (k < 3000 && !((got_q.size() - g0 >= exp_q.size()) && cmd_ready)) begin
      @(posedge clk); #1;
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
      k++;
    end
    rsp_ready = 1;
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic start_scenario();
    exp_q.delete(); exp_addr.delete(); exp_err = 0;
  endtask

  task automatic test_reset();
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_incr = 0;
    cmd_addr = '0; cmd_wdata = '0; cmd_len = '0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, mem_rd_en, mem_wr_en, cmd_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000",
                         {cmd_ready, rsp_valid, mem_rd_en, mem_wr_en, cmd_err});
    end
    n_cmp++;
    if ({mem_addr, mem_wdata, rsp_data, rsp_last} !== '0) begin
      n_fail++; $display("FAIL reset_data got=%h exp=0", {mem_addr, mem_wdata, rsp_data, rsp_last});
    end
    reset = 0; #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_clk got=%b exp=0", cmd_ready); end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_clk got=%b exp=1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_read_burst();
    int g0 = got_q.size(), r0 = rd_addr_q.size();
    start_scenario(); rsp_ready = 1;
    send(0, 0, 0, 0, 7);
    drain(g0);
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      n_fail++; $display("FAIL rd8_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[g0+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rd8_beat%0d got=%h exp=%h", i, got_q[g0+i], exp_q[i]);
      end
    end
    n_cmp++;
    if (rd_addr_q.size() - r0 !== 8) begin
      n_fail++; $display("FAIL rd8_issue_count got=%0d exp=8", rd_addr_q.size() - r0);
    end
    if (rd_cyc.size() - r0 >= 8) begin
      n_cmp++;
      if (rd_cyc[r0+7] - rd_cyc[r0] !== 7) begin
        n_fail++; $display("FAIL rd8_issue_span got=%0d exp=7", rd_cyc[r0+7] - rd_cyc[r0]);
      end
    end
    if (got_cyc.size() - g0 >= 8) begin
      n_cmp++;
      if (got_cyc[g0+7] - got_cyc[g0] !== 7) begin
        n_fail++; $display("FAIL rd8_rsp_span got=%0d exp=7", got_cyc[g0+7] - got_cyc[g0]);
      end
    end
  endtask

  task automatic test_write_incr();
    int g0 = got_q.size(), w0 = wr_cnt;
    start_scenario(); rsp_ready = 1;
    send(1, 1, 2, 8'h10, 3);
    send(0, 0, 2, 0, 3);
    drain(g0);
    n_cmp++;
    if (wr_cnt - w0 !== 4) begin n_fail++; $display("FAIL wincr_wr_cycles got=%0d exp=4", wr_cnt - w0); end
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      n_fail++; $display("FAIL wincr_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[g0+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wincr_beat%0d got=%h exp=%h", i, got_q[g0+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_write_wrap();
    int g0 = got_q.size(), r0 = rd_addr_q.size(), e0 = err_cnt;
    start_scenario(); rsp_ready = 1;
    send(1, 0, 6, 8'hA5, 3);
    send(0, 0, 6, 0, 3);
    drain(g0);
    n_cmp++;
    if (err_cnt - e0 !== exp_err) begin
      n_fail++; $display("FAIL wrap_err got=%0d exp=%0d", err_cnt - e0, exp_err);
    end
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[g0+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_beat%0d got=%h exp=%h", i, got_q[g0+i], exp_q[i]);
      end
    end
    for (int i = 0; i < exp_addr.size() && r0 + i < rd_addr_q.size(); i++) begin
      n_cmp++;
      if (rd_addr_q[r0+i] !== exp_addr[i]) begin
        n_fail++; $display("FAIL wrap_addr%0d got=%0d exp=%0d", i, rd_addr_q[r0+i], exp_addr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int g0 = got_q.size(), r0 = rd_addr_q.size();
    start_scenario(); rsp_ready = 0;
    send(0, 0, 0, 0, 7);
    repeat (10) begin @(posedge clk); #1; end
    n_cmp++;
    if (rd_addr_q.size() - r0 > DEPTH) begin
      n_fail++; $display("FAIL bp_issued got=%0d exp<=%0d", rd_addr_q.size() - r0, DEPTH);
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid_held got=%b exp=1", rsp_valid); end
    rsp_ready = 1;
    drain(g0);
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[g0+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL bp_beat%0d got=%h exp=%h", i, got_q[g0+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int gr;
    start_scenario(); rsp_ready = 1;
    send(0, 0, 0, 0, 7);
    repeat (2) begin @(posedge clk); #1; end
    reset = 1; #1;
    gr = got_q.size();
    n_cmp++;
    if ({cmd_ready, rsp_valid, mem_rd_en} !== 3'b0) begin
      n_fail++; $display("FAIL midrst_outputs got=%b exp=000", {cmd_ready, rsp_valid, mem_rd_en});
    end
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, mem_rd_en} !== 3'b0) begin
      n_fail++; $display("FAIL midrst_held got=%b exp=000", {cmd_ready, rsp_valid, mem_rd_en});
    end
    reset = 0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", cmd_ready); end
    n_cmp++;
    if (got_q.size() !== gr) begin
      n_fail++; $display("FAIL midrst_stale got=%0d exp=0", got_q.size() - gr);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_rd_then_wr();
    int g0 = got_q.size();
    start_scenario(); rsp_ready = 1;
    send(0, 0, 1, 0, 0);
    send(1, 0, 1, 8'h55, 0);
    send(0, 0, 1, 0, 0);
    drain(g0);
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      n_fail++; $display("FAIL rdwr_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[g0+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rdwr_beat%0d got=%h exp=%h", i, got_q[g0+i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int g0 = got_q.size(), e0 = err_cnt;
    start_scenario(); rnd_ready = 1;
    for (int n = 0; n < 24; n++)
      send(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, NW - 1),
           $urandom_range(0, 255), $urandom_range(0, (1 << LW) - 1));
    drain(g0);
    rnd_ready = 0;
    n_cmp++;
    if (got_q.size() - g0 !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size() - g0, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && g0 + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[g0+i] !== exp_q[i]) begin
        n_fail++; $display("FAIL rand_beat%0d got=%h exp=%h", i, got_q[g0+i], exp_q[i]);
      end
    end
    n_cmp++;
    if (err_cnt - e0 !== exp_err) begin
      n_fail++; $display("FAIL rand_err got=%0d exp=%0d", err_cnt - e0, exp_err);
    end
    n_cmp++;
    if (both_cnt !== 0) begin n_fail++; $display("FAIL rd_wr_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    for (int i = 0; i < NW; i++) ref_mem[i] = 8'hFF;
    test_reset();
    test_read_burst();
    test_write_incr();
    test_write_wrap();
    test_backpressure();
    test_reset_mid();
    test_rd_then_wr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout reached at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
